// File: rtl/sp_interp_line.sv
// sp_interp_line: streaming H.264 6-tap half-pel line interpolator.
// Define SP_INTERP_QPEL_EN to add the quarter-pel output out_qpel_o.
module sp_interp_line #(
  parameter int PIX_W   = 8,
  parameter int MIN_LEN = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [PIX_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PIX_W-1:0] out_data_o,
  output logic             out_last_o,
`ifdef SP_INTERP_QPEL_EN
  output logic [PIX_W-1:0] out_qpel_o,
`endif
  output logic             done_o,
  output logic             err_o
);
  localparam int CW = $clog2(MIN_LEN + 1);
  localparam int SW = PIX_W + 7;
  localparam int AW = PIX_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [5:0][PIX_W-1:0] win_q, win_d;
  logic                  iss_q, iss_d;
  logic                  isl_q, isl_d;
  logic                  err_q, err_d;
  logic                  done_q;
  logic                  s1_v_q, s1_l_q;
  logic [AW-1:0]         s1_a_q, s1_b_q, s1_c_q;
  logic                  out_v_q, out_l_q;
  logic [PIX_W-1:0]      out_d_q;
  logic                  stall, acc;
  logic signed [SW-1:0]  a_s, b_s, c_s;
  logic signed [SW-1:0]  sum_s, sh_s;
  logic [PIX_W-1:0]      h;

  assign stall      = out_v_q && !out_ready_i;
  assign in_ready_o = !stall;
  assign acc        = in_valid_i && !stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    iss_d   = 1'b0;
    isl_d   = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      win_d = {in_data_i, win_q[5:1]};
      case (state_q)
        IDLE: begin
          state_d = FILL;
          cnt_d   = CW'(1);
        end
        FILL: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MIN_LEN - 1)) begin
            state_d = RUN;
            iss_d   = 1'b1;
          end
        end
        RUN:     iss_d = 1'b1;
        default: state_d = IDLE;
      endcase
      // A short line leaves nothing behind for the next one.
      if (in_last_i) begin
        state_d = IDLE;
        cnt_d   = '0;
        isl_d   = iss_d;
        err_d   = !iss_d;
        if (!iss_d) win_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '0;
      iss_q   <= 1'b0;
      isl_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      err_q   <= err_d;
      done_q  <= out_v_q && out_ready_i && out_l_q;
      if (!stall) begin
        iss_q <= iss_d;
        isl_q <= isl_d;
      end
    end
  end

`ifdef SP_INTERP_QPEL_EN
  logic [PIX_W-1:0] s1_p2_q, out_q_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_l_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_c_q <= '0;
`ifdef SP_INTERP_QPEL_EN
      s1_p2_q <= '0;
`endif
    end else if (!stall) begin
      s1_v_q <= iss_q;
      s1_l_q <= isl_q;
      if (iss_q) begin
        s1_a_q <= AW'(win_q[0]) + AW'(win_q[5]);
        s1_b_q <= AW'(win_q[1]) + AW'(win_q[4]);
        s1_c_q <= AW'(win_q[2]) + AW'(win_q[3]);
`ifdef SP_INTERP_QPEL_EN
        s1_p2_q <= win_q[2];
`endif
      end
    end
  end

  // a - 5b + 20c + 16, built from shifts to keep every term SW wide.
  always_comb begin
    a_s   = $signed(SW'(s1_a_q));
    b_s   = $signed(SW'(s1_b_q));
    c_s   = $signed(SW'(s1_c_q));
    sum_s = a_s - (b_s <<< 2) - b_s
          + (c_s <<< 4) + (c_s <<< 2) + SW'(16);
    sh_s  = sum_s >>> 5;
    if (sh_s[SW-1])             h = '0;
    else if (|sh_s[SW-2:PIX_W]) h = '1;
    else                        h = sh_s[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      out_l_q <= 1'b0;
      out_d_q <= '0;
`ifdef SP_INTERP_QPEL_EN
      out_q_q <= '0;
`endif
    end else if (!stall) begin
      out_v_q <= s1_v_q;
      out_l_q <= s1_v_q && s1_l_q;
      if (s1_v_q) begin
        out_d_q <= h;
`ifdef SP_INTERP_QPEL_EN
        out_q_q <= PIX_W'((AW'(s1_p2_q) + AW'(h) + AW'(1)) >> 1);
`endif
      end
    end
  end

  assign out_valid_o = out_v_q;
  assign out_data_o  = out_d_q;
  assign out_last_o  = out_l_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef SP_INTERP_QPEL_EN
  assign out_qpel_o  = out_q_q;
`endif

endmodule

// File: tb/tb_sp_interp_line.sv
// Directed bench for sp_interp_line: flat, filter, clip, short line,
// backpressure and mid-line reset scenarios.
module tb_sp_interp_line;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       done, err;
`ifdef SP_INTERP_QPEL_EN
  logic [7:0] out_qpel;
  logic [7:0] qq[$];
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [8:0] q[$];

  sp_interp_line dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
`ifdef SP_INTERP_QPEL_EN
    .out_qpel_o (out_qpel),
`endif
    .done_o     (done),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q.push_back({out_last, out_data});
`ifdef SP_INTERP_QPEL_EN
      qq.push_back(out_qpel);
`endif
    end
    if (rst_n && done) done_cnt <= done_cnt + 1;
    if (rst_n && err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_line(input string tag, input int exp[$]);
    logic [8:0] e;
    chk({tag, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (q.size() == 0) break;
      e = q.pop_front();
      chk($sformatf("%s_data%0d", tag, i), e[7:0], exp[i]);
      chk($sformatf("%s_last%0d", tag, i), e[8], i == exp.size() - 1);
    end
    q.delete();
`ifdef SP_INTERP_QPEL_EN
    qq.delete();
`endif
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
    chk({tag, "_in_ready"},  in_ready,  1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(2);
    reset_vals("por");
    rst_n = 1'b1;
    idle(1);

    // flat line of 10s
    repeat (7) send(8'd10, 1'b0);
    send(8'd10, 1'b1);
    idle(1);
    chk("flat_valid", out_valid, 1);
    idle(1);
    chk("flat_out_last", out_last, 1);
    chk("flat_last_data", out_data, 10);
    chk("flat_done_early", done, 0);
    idle(1);
    chk("flat_done_pulse", done, 1);
    chk("flat_drained", out_valid, 0);
    idle(3);
    check_line("flat", '{10, 10, 10});
    chk("flat_done_cnt", done_cnt, 1);

    // filter values, latency and backpressure
    send(8'd3, 1'b0);
    send(8'd14, 1'b0);
    send(8'd12, 1'b0);
    send(8'd11, 1'b0);
    send(8'd15, 1'b0);
    send(8'd19, 1'b0);
    chk("lat_t0", out_valid, 0);
    idle(1);
    chk("lat_t1", out_valid, 0);
    idle(1);
    chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_data", out_data, 11);
    send(8'd34, 1'b0);
    send(8'd78, 1'b0);
    idle(1);
    chk("bp_pre_valid", out_valid, 1);
    chk("bp_pre_data", out_data, 13);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
      chk($sformatf("bp_hold%0d", i), out_data, 13);
    end
    out_ready = 1'b1;
    send(8'd100, 1'b0);
    send(8'd50, 1'b1);
    idle(8);
`ifdef SP_INTERP_QPEL_EN
    chk("qpel_n", qq.size(), 5);
    if (qq.size() >= 3) begin
      chk("qpel0", qq[0], 12);
      chk("qpel1", qq[1], 12);
      chk("qpel2", qq[2], 16);
    end
`endif
    check_line("bp", '{11, 13, 17, 22, 53});
    chk("bp_done_cnt", done_cnt, 2);

    // clipping
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b1);
    idle(6);
    check_line("clip_hi", '{255});
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd0, 1'b0);
    send(8'd0, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b1);
    idle(6);
    check_line("clip_lo", '{0});

    // short line then a minimum-length line
    repeat (3) send(8'd10, 1'b0);
    send(8'd10, 1'b1);
    chk("short_err_pulse", err, 1);
    chk("short_no_valid", out_valid, 0);
    idle(1);
    chk("short_err_clear", err, 0);
    idle(4);
    chk("short_err_cnt", err_cnt, 1);
    check_line("short", '{});
    repeat (5) send(8'd10, 1'b0);
    send(8'd10, 1'b1);
    idle(6);
    check_line("min_line", '{10});
    chk("min_done_cnt", done_cnt, 5);

    // reset after the 7th pixel of a 10-pixel line
    repeat (7) send(8'd50, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_vals("mid_rst");
    idle(1);
    rst_n = 1'b1;
    idle(1);
    reset_vals("post_rst");
    repeat (7) send(8'd20, 1'b0);
    send(8'd20, 1'b1);
    idle(8);
    check_line("after_rst", '{20, 20, 20});
    chk("after_rst_done_cnt", done_cnt, 6);
    chk("after_rst_err_cnt", err_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
